channel_scan_arbiter: RTL and testbench
=======================================

CHANNEL_SCAN_ARBITER -- requirements
Module: channel_scan_arbiter

Interface
REQ-001 Parameter: DWELL, default 4, maximum handshake beats per grant; legal range 1..16.
REQ-002 Port: clk  input  1  single clock; all logic updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  8  per-channel request; bit i requests data word i of the downstream 8:1 registered mux.
REQ-005 Port: ready  input  1  downstream accepts the current select this cycle.
REQ-006 Port: sel  output  3  registered channel index driven to the downstream mux select.
REQ-007 Port: sel_valid  output  1  sel holds a live grant.
REQ-008 Port: grant  output  8  registered one-hot copy of sel; all zero when sel_valid=0.
REQ-009 Port: last  output  1  current beat is the final beat of this grant.

Function
REQ-010 The block SHALL implement two states, IDLE and HOLD.
REQ-011 A round-robin pointer ptr[2:0] SHALL select the first asserted req bit at or above ptr, searching upward modulo 8.
REQ-012 In IDLE, sel_valid=0. When req≠0 at edge N, the block SHALL enter HOLD with sel_valid=1 after edge N; latency is one cycle.
REQ-013 A beat SHALL occur on each cycle where sel_valid=1 and ready=1. A beat counter SHALL increment on each beat.
REQ-014 In HOLD, sel and grant SHALL be stable until the grant is released.
REQ-015 The grant SHALL release on the beat where the counter equals DWELL-1. It SHALL also release on any cycle where req[sel]=0, whether or not ready is asserted.
REQ-016 last SHALL equal 1 when sel_valid=1 and either the counter equals DWELL-1 or req[sel]=0.
REQ-017 On release, ptr SHALL be set to sel+1 mod 8, with 7 wrapping to 0.
REQ-018 On release, arbitration SHALL use the updated ptr and the current req.
  - If any req is set, the next grant SHALL start on the following cycle with no IDLE bubble.
  - Otherwise the block SHALL return to IDLE.
REQ-019 The released channel SHALL be granted again only if no other channel requests.
REQ-020 Changes on req bits other than req[sel] during HOLD SHALL NOT affect the current grant.
REQ-021 The beat counter SHALL clear to 0 on every new grant.
REQ-022 The beat counter SHALL be 4 bits wide. With DWELL=16 it reaches 15 and releases there, so no wrap-around occurs.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL drive: state=IDLE, ptr=0, counter=0, sel=0, sel_valid=0, grant=0, last=0.
REQ-024 rst SHALL take priority over all other inputs. Asserting rst mid-grant SHALL abort the grant; the block never completes it.
REQ-025 The first edge after rst deasserts SHALL perform normal IDLE arbitration from ptr=0.

Configuration
REQ-026 Macro DWELL_TIMER_EN: defined -> multi-beat grants per REQ-013..REQ-016 using DWELL.
REQ-027 Macro DWELL_TIMER_EN: undefined -> every grant SHALL release after exactly one beat, or earlier on req drop.
  - DWELL is ignored and no beat counter is instantiated.
  - last = sel_valid.

Verification
REQ-028 Scenario 1 (rst held 2 cycles, then req=8'h00 for 5 cycles): sel_valid=0, grant=8'h00, sel=0 throughout.
REQ-029 Scenario 2 (DWELL=4, req=8'h01 steady, ready=1): sel=0 and sel_valid=1 one cycle after req.
  - last=1 on the 4th beat.
  - Channel 0 is re-granted immediately with no bubble.
REQ-030 Scenario 3 (req=8'hFF, ready=1, DWELL=2): sel sequence 0,0,1,1,2,2,…,7,7,0,0; grant stays one-hot matching sel.
REQ-031 Scenario 4 (grant on ch 5, ready=0 for 3 cycles): sel=5 stays stable and the counter stays 0.
  - Dropping req[5] causes last=1 that cycle.
  - The next grant goes to the lowest requester at or above 6, wrapping past 7 to 0.
REQ-032 Scenario 5 (rst=1 during beat 2 of a grant on ch 3): outputs reach reset values after the edge; the next grant searches from ptr=0.
REQ-033 Scenario 6 (DWELL_TIMER_EN undefined, req=8'h81, ready=1): sel alternates 0,7,0,7 with last=1 every cycle.

Source files
------------

// File: rtl/channel_scan_arbiter.sv
// channel_scan_arbiter: round-robin grant of one of 8 channels to a downstream
// registered 8:1 mux. A grant is held until it has run its beats or its
// request drops. The next grant is then issued with no idle cycle.
// Macro DWELL_TIMER_EN: defined -> grants last up to DWELL beats;
// undefined -> every grant is a single beat and DWELL is ignored.
module channel_scan_arbiter #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ready,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic [7:0] grant,
    output logic       last
);

    localparam int unsigned NCH = 8;
    localparam int unsigned IW  = 3;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] sel_n;
    logic          sel_valid_n;
    logic [NCH-1:0] grant_n;
    logic [IW-1:0] scan_base;
    logic [IW-1:0] pick;
    logic          release_c;
    logic          req_sel;

    // First asserted request at or above base, searching upward modulo 8.
    function automatic logic [IW-1:0] scan(input logic [NCH-1:0] r, input logic [IW-1:0] base);
        logic [IW-1:0] idx;
        logic [IW-1:0] res;
        res = base;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = base + IW'(i);
            if (r[idx]) res = idx;
        end
        return res;
    endfunction

    assign req_sel = req[sel];

`ifdef DWELL_TIMER_EN
    localparam int unsigned CW = 4;

    logic [CW-1:0] cnt, cnt_n;
    logic          at_end;

    assign at_end    = (cnt == CW'(DWELL - 1));
    assign last      = sel_valid && (at_end || !req_sel);
    assign release_c = sel_valid && ((ready && at_end) || !req_sel);

    // Beat counter: cleared on each new grant, advances on every beat.
    always_comb begin
        cnt_n = cnt;
        if ((state == IDLE) || release_c) begin
            cnt_n = '0;
        end else if (ready) begin
            cnt_n = cnt + CW'(1);
        end
    end

    // Beat counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_n;
    end
`else
    logic unused_dwell;

    // DWELL has no effect in single-beat mode.
    assign unused_dwell = ^(32'(DWELL));
    assign last         = sel_valid;
    assign release_c    = sel_valid && (ready || !req_sel);
`endif

    // A released grant restarts the search just above the released channel.
    assign scan_base = (state == HOLD) ? (sel + IW'(1)) : ptr;
    assign pick      = scan(req, scan_base);

    // Next-state and next-grant logic.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        sel_n       = sel;
        sel_valid_n = sel_valid;
        grant_n     = grant;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    state_n     = HOLD;
                    sel_n       = pick;
                    sel_valid_n = 1'b1;
                    grant_n     = NCH'(1) << pick;
                end
            end
            HOLD: begin
                if (release_c) begin
                    ptr_n = sel + IW'(1);
                    if (req != '0) begin
                        sel_n   = pick;
                        grant_n = NCH'(1) << pick;
                    end else begin
                        state_n     = IDLE;
                        sel_valid_n = 1'b0;
                        grant_n     = '0;
                    end
                end
            end
            default: begin
                state_n     = IDLE;
                sel_valid_n = 1'b0;
                grant_n     = '0;
            end
        endcase
    end

    // State, pointer and registered select outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            grant     <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            sel       <= sel_n;
            sel_valid <= sel_valid_n;
            grant     <= grant_n;
        end
    end

endmodule

// File: tb/tb_channel_scan_arbiter.sv
// Bench for channel_scan_arbiter: directed vector table plus short
// hand-written sequences. Build with or without DWELL_TIMER_EN.
module tb_channel_scan_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic [2:0] sel;
    logic       sel_valid;
    logic [7:0] grant;
    logic       last;

    int checks = 0;
    int errors = 0;

    channel_scan_arbiter #(.DWELL(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ready    (ready),
        .sel      (sel),
        .sel_valid(sel_valid),
        .grant    (grant),
        .last     (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       ready;
        logic [2:0] sel;
        logic       valid;
        logic [7:0] grant;
        logic       last;
        logic       chk_sel;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] q, input logic rd);
        @(negedge clk);
        rst   = r;
        req   = q;
        ready = rd;
        #1;
    endtask

`ifndef DWELL_TIMER_EN
    localparam int NV = 23;
    vec_t tv [NV];
`endif

    initial begin
        rst   = 1'b1;
        req   = 8'h00;
        ready = 1'b0;
        repeat (2) @(posedge clk);

`ifndef DWELL_TIMER_EN
        // Outputs listed are those seen before the edge that samples the inputs.
        tv[0]  = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[1]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[2]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[3]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[4]  = '{1'b0, 8'h81, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 8'h81, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1, 1'b1};
        tv[6]  = '{1'b0, 8'h81, 1'b1, 3'd7, 1'b1, 8'h80, 1'b1, 1'b1};
        tv[7]  = '{1'b0, 8'h81, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1, 1'b1};
        tv[8]  = '{1'b0, 8'h81, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b1};
        tv[9]  = '{1'b0, 8'h81, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b1};
        tv[10] = '{1'b0, 8'h01, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b1};
        tv[11] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h01, 1'b1, 1'b1};
        tv[12] = '{1'b0, 8'h20, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[13] = '{1'b0, 8'h20, 1'b0, 3'd5, 1'b1, 8'h20, 1'b1, 1'b1};
        tv[14] = '{1'b0, 8'h60, 1'b0, 3'd5, 1'b1, 8'h20, 1'b1, 1'b1};
        tv[15] = '{1'b0, 8'h41, 1'b0, 3'd5, 1'b1, 8'h20, 1'b1, 1'b1};
        tv[16] = '{1'b0, 8'h01, 1'b1, 3'd6, 1'b1, 8'h40, 1'b1, 1'b1};
        tv[17] = '{1'b0, 8'h08, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1, 1'b1};
        tv[18] = '{1'b1, 8'h08, 1'b0, 3'd3, 1'b1, 8'h08, 1'b1, 1'b1};
        tv[19] = '{1'b0, 8'h09, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[20] = '{1'b0, 8'h09, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1, 1'b1};
        tv[21] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h08, 1'b1, 1'b1};
        tv[22] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};

        for (int k = 0; k < NV; k++) begin
            drive(tv[k].rst, tv[k].req, tv[k].ready);
            if (tv[k].valid || tv[k].chk_sel)
                check($sformatf("sel[%0d]", k), 32'(sel), 32'(tv[k].sel));
            check($sformatf("sel_valid[%0d]", k), 32'(sel_valid), 32'(tv[k].valid));
            check($sformatf("grant[%0d]", k), 32'(grant), 32'(tv[k].grant));
            check($sformatf("last[%0d]", k), 32'(last), 32'(tv[k].last));
        end

        // Grant on ch 2 (search from 4 wraps), held while other requests churn.
        drive(1'b0, 8'h04, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 8'($urandom) | 8'h04, 1'b0);
            check($sformatf("hold_sel[%0d]", k), 32'(sel), 32'd2);
            check($sformatf("hold_grant[%0d]", k), 32'(grant), 32'h04);
            check($sformatf("hold_last[%0d]", k), 32'(last), 32'd1);
        end
        // Dropping req[2] releases without ready; search resumes from 3.
        drive(1'b0, 8'h10, 1'b0);
        check("drop_last", 32'(last), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        check("after_drop_sel", 32'(sel), 32'd4);
        check("after_drop_grant", 32'(grant), 32'h10);
        drive(1'b0, 8'h00, 1'b0);
        check("idle_valid", 32'(sel_valid), 32'd0);
        check("idle_grant", 32'(grant), 32'h00);
`else
        // Reset state, then all channels requesting with DWELL=2.
        drive(1'b1, 8'h00, 1'b0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(sel_valid), 32'd0);
        check("rst_grant", 32'(grant), 32'h00);
        check("rst_last", 32'(last), 32'd0);
        drive(1'b0, 8'hFF, 1'b1);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rr_sel[%0d]", k), 32'(sel), 32'((k / 2) % 8));
            check($sformatf("rr_grant[%0d]", k), 32'(grant), 32'(8'(1) << ((k / 2) % 8)));
            check($sformatf("rr_last[%0d]", k), 32'(last), 32'(k % 2));
        end
        // Stall on ch 1: counter must not advance while ready is low.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 8'hFF, 1'b0);
            check($sformatf("stall_sel[%0d]", k), 32'(sel), 32'd1);
            check($sformatf("stall_last[%0d]", k), 32'(last), 32'd0);
        end
        drive(1'b0, 8'hFF, 1'b1);
        check("beat0_last", 32'(last), 32'd0);
        drive(1'b0, 8'hFF, 1'b1);
        check("beat1_sel", 32'(sel), 32'd1);
        check("beat1_last", 32'(last), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
